// File: rtl/snn_pool_event_encoder.sv
// snn_pool_event_encoder: turns a raster-ordered pooled feature stream into AER event words buffered in a small FIFO.
module snn_pool_event_encoder #(
  parameter int MAP_WIDTH  = 14,
  parameter int MAP_HEIGHT = 14,
  parameter int CHANNELS   = 32,
  parameter int DATA_WIDTH = 8,
  parameter int THRESHOLD  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [DATA_WIDTH-1:0]           s_axis_input_tdata,
  input  logic                            s_axis_input_tvalid,
  output logic                            s_axis_input_tready,
  input  logic                            s_axis_input_tlast,
  input  logic [7:0]                      s_axis_input_tuser,
  output logic [24+DATA_WIDTH-1:0]        m_axis_event_tdata,
  output logic                            m_axis_event_tvalid,
  input  logic                            m_axis_event_tready,
  output logic                            m_axis_event_tlast,
  output logic                            m_axis_event_tuser,
  output logic [31:0]                     event_count,
  output logic [31:0]                     frame_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            sync_error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 24 + DATA_WIDTH;
  localparam int MW = EW + 2;
  localparam logic [7:0] X_MAX = 8'(MAP_WIDTH - 1);
  localparam logic [7:0] Y_MAX = 8'(MAP_HEIGHT - 1);
  localparam logic [7:0] C_MAX = 8'(CHANNELS - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] THR = DATA_WIDTH'(THRESHOLD);
  logic [MW-1:0] mem_q [FIFO_DEPTH];
  logic [MW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0] x_q, x_d, y_q, y_d, ch_q, ch_d;
  logic [31:0] event_count_q, event_count_d, frame_count_q, frame_count_d;
  logic sync_error_q, sync_error_d;
  logic full, empty, accept, pop, push, hit, pos_last, frame_end;
  logic [MW-1:0] head, word;
  always_comb begin
    full = level_q == FULL_LVL;
    empty = level_q == '0;
    s_axis_input_tready = enable && !full;
    accept = s_axis_input_tvalid && s_axis_input_tready;
    head = mem_q[rd_ptr_q];
    pop = !empty && m_axis_event_tready;
    pos_last = x_q == X_MAX && y_q == Y_MAX && ch_q == C_MAX;
    frame_end = pos_last || s_axis_input_tlast;
    hit = s_axis_input_tdata > THR;
    push = accept && (hit || frame_end);
    // Low bits of each entry: tlast, then tuser (set only for a marker word).
    word = {ch_q, y_q, x_q, hit ? s_axis_input_tdata : DATA_WIDTH'(0), frame_end, !hit};
    m_axis_event_tvalid = !empty;
    m_axis_event_tdata = empty ? EW'(0) : head[MW-1:2];
    m_axis_event_tlast = !empty && head[1];
    m_axis_event_tuser = !empty && head[0];
    event_count = event_count_q;
    frame_count = frame_count_q;
    fifo_level = level_q;
    sync_error = sync_error_q;
  end
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = word;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d = level_q + LW'(push) - LW'(pop);
    event_count_d = event_count_q + 32'(pop && !head[0]);
    frame_count_d = frame_count_q + 32'(accept && frame_end);
    sync_error_d = sync_error_q || (accept && (s_axis_input_tuser != ch_q || s_axis_input_tlast != pos_last));
    x_d = x_q;
    y_d = y_q;
    ch_d = ch_q;
    if (accept) begin
      x_d = (frame_end || x_q == X_MAX) ? 8'd0 : x_q + 8'd1;
      y_d = (frame_end || (x_q == X_MAX && y_q == Y_MAX)) ? 8'd0 : y_q + 8'(x_q == X_MAX);
      ch_d = frame_end ? 8'd0 : ch_q + 8'(x_q == X_MAX && y_q == Y_MAX);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      x_q <= '0;
      y_q <= '0;
      ch_q <= '0;
      event_count_q <= '0;
      frame_count_q <= '0;
      sync_error_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      x_q <= x_d;
      y_q <= y_d;
      ch_q <= ch_d;
      event_count_q <= event_count_d;
      frame_count_q <= frame_count_d;
      sync_error_q <= sync_error_d;
    end
  end
endmodule

// File: tb/tb_snn_pool_event_encoder.sv
// tb_snn_pool_event_encoder: directed checks of event encoding, markers, backpressure, framing errors and reset on a 2x2x2 map.
module tb_snn_pool_event_encoder;
  logic clk = 0, reset = 1, enable = 1;
  logic [7:0] s_tdata = 0, s_tuser = 0;
  logic s_tvalid = 0, s_tready, s_tlast = 0;
  logic [31:0] m_tdata;
  logic m_tvalid, m_tready = 0, m_tlast, m_tuser;
  logic [31:0] event_count, frame_count;
  logic [2:0] fifo_level;
  logic sync_error;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  snn_pool_event_encoder #(.MAP_WIDTH(2), .MAP_HEIGHT(2), .CHANNELS(2), .DATA_WIDTH(8), .THRESHOLD(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_axis_input_tdata(s_tdata), .s_axis_input_tvalid(s_tvalid), .s_axis_input_tready(s_tready),
    .s_axis_input_tlast(s_tlast), .s_axis_input_tuser(s_tuser),
    .m_axis_event_tdata(m_tdata), .m_axis_event_tvalid(m_tvalid), .m_axis_event_tready(m_tready),
    .m_axis_event_tlast(m_tlast), .m_axis_event_tuser(m_tuser),
    .event_count(event_count), .frame_count(frame_count), .fifo_level(fifo_level), .sync_error(sync_error));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [7:0] v, input logic l, input logic [7:0] u);
    int n = 0;
    s_tdata = v;
    s_tlast = l;
    s_tuser = u;
    s_tvalid = 1;
    while (!s_tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("beat_timeout", s_tready, 1);
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 0;
    s_tlast = 0;
  endtask
  task automatic pop(input string tag, input logic [31:0] d, input logic l, input logic u);
    chk({tag, ".tvalid"}, m_tvalid, 1);
    chk({tag, ".tdata"}, m_tdata, d);
    chk({tag, ".tlast"}, m_tlast, l);
    chk({tag, ".tuser"}, m_tuser, u);
    m_tready = 1;
    @(posedge clk);
    @(negedge clk);
    m_tready = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    #2;
    chk("rst.tvalid", m_tvalid, 0);
    chk("rst.tdata", m_tdata, 0);
    chk("rst.level", fifo_level, 0);
    chk("rst.events", event_count, 0);
    chk("rst.frames", frame_count, 0);
    chk("rst.sync", sync_error, 0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) beat(8'd0, i == 7, 8'(i >> 2));
    chk("t1.level", fifo_level, 1);
    pop("t1.marker", 32'h01010100, 1, 1);
    chk("t1.events", event_count, 0);
    chk("t1.frames", frame_count, 1);
    chk("t1.sync", sync_error, 0);
    chk("t1.empty", m_tvalid, 0);
    for (int i = 0; i < 8; i++) beat(i == 1 ? 8'd5 : (i == 7 ? 8'd9 : 8'd0), i == 7, 8'(i >> 2));
    pop("t2.ev0", 32'h00000105, 0, 0);
    pop("t2.ev1", 32'h01010109, 1, 0);
    chk("t2.events", event_count, 2);
    chk("t2.frames", frame_count, 2);
    for (int i = 0; i < 4; i++) beat(8'd3, 0, 8'd0);
    chk("t3.full_tready", s_tready, 0);
    chk("t3.full_level", fifo_level, 4);
    for (int i = 4; i < 8; i++) begin
      pop($sformatf("t3.ev%0d", i - 4), {8'((i - 4) >> 2), 8'(((i - 4) >> 1) & 1), 8'((i - 4) & 1), 8'd3}, 0, 0);
      beat(8'd3, i == 7, 8'(i >> 2));
    end
    for (int i = 4; i < 8; i++) pop($sformatf("t3.ev%0d", i), {8'(i >> 2), 8'((i >> 1) & 1), 8'(i & 1), 8'd3}, i == 7, 0);
    chk("t3.events", event_count, 10);
    chk("t3.frames", frame_count, 3);
    chk("t3.sync", sync_error, 0);
    beat(8'd0, 0, 8'd0);
    beat(8'd0, 0, 8'd0);
    beat(8'd0, 1, 8'd0);
    chk("t4.sync", sync_error, 1);
    chk("t4.frames", frame_count, 4);
    beat(8'd7, 0, 8'd0);
    pop("t4.marker", 32'h00010000, 1, 1);
    pop("t4.restart", 32'h00000007, 0, 0);
    chk("t4.events", event_count, 11);
    do_reset();
    chk("t5.sync_clr", sync_error, 0);
    beat(8'd0, 0, 8'd0);
    beat(8'd4, 0, 8'd1);
    chk("t5.sync_set", sync_error, 1);
    pop("t5.ev", 32'h00000104, 0, 0);
    for (int i = 2; i < 8; i++) beat(8'd0, i == 7, 8'(i >> 2));
    pop("t5.marker", 32'h01010100, 1, 1);
    chk("t5.sync_sticky", sync_error, 1);
    chk("t5.frames", frame_count, 1);
    for (int i = 0; i < 3; i++) beat(8'd1, 0, 8'd0);
    chk("t6.level_pre", fifo_level, 3);
    reset = 1;
    #1;
    chk("t6.tvalid", m_tvalid, 0);
    chk("t6.level", fifo_level, 0);
    @(negedge clk);
    reset = 0;
    chk("t6.events", event_count, 0);
    chk("t6.frames", frame_count, 0);
    chk("t6.sync", sync_error, 0);
    beat(8'd2, 0, 8'd0);
    pop("t6.first", 32'h00000002, 0, 0);
    chk("t6.events_after", event_count, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
